// File: rtl/waveform_generator.sv
// Periodic sample source for the amplitude selector: saw, triangle, square and
// reverse saw built from one phase counter, an up/down direction FSM and a prescaler.
module waveform_generator #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       waveSel,
    output logic [WIDTH-1:0] dataOut,
    output logic             periodEnd
);

    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam int               PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dirT;

    logic [WIDTH-1:0] phase;
    logic [WIDTH-1:0] nextPhase;
    dirT              dir;
    dirT              nextDir;
    logic [PW-1:0]    prescaler;
    logic [1:0]       modeReg;
    logic             step;

    assign step = enable && (prescaler == PRE_LAST);

    // Triangle turns around on the step after reaching an end, so MAX and 0
    // are each held for one step only.
    always_comb begin
        nextPhase = phase + 1'b1;
        nextDir   = dir;
        if (modeReg == 2'b01) begin
            if (dir == UP) begin
                if (phase == MAX) begin
                    nextDir   = DOWN;
                    nextPhase = MAX - 1'b1;
                end
            end else if (phase == '0) begin
                nextDir   = UP;
                nextPhase = WIDTH'(1);
            end else begin
                nextPhase = phase - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= '0;
            dir       <= UP;
            prescaler <= '0;
            modeReg   <= 2'b00;
            periodEnd <= 1'b0;
        end else if (waveSel != modeReg) begin
            phase     <= '0;
            dir       <= UP;
            prescaler <= '0;
            modeReg   <= waveSel;
            periodEnd <= 1'b0;
        end else begin
            periodEnd <= step && (nextPhase == '0);
            if (step) begin
                phase     <= nextPhase;
                dir       <= nextDir;
                prescaler <= '0;
            end else if (enable) begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    always_comb begin
        dataOut = phase;
        case (modeReg)
            2'b10:   dataOut = phase[WIDTH-1] ? '0 : MAX;
            2'b11:   dataOut = MAX - phase;
            default: dataOut = phase;
        endcase
    end

endmodule
